// File: rtl/game_timer_lives_pkg.sv
// Shared one-hot state encodings for the game FSM, its datapath companion and the display logic.
package game_timer_lives_pkg;

    localparam int NUM_STATES = 6;

    localparam logic [NUM_STATES-1:0] ST_STARTGAME  = 6'b000001;
    localparam logic [NUM_STATES-1:0] ST_IDLE       = 6'b000010;
    localparam logic [NUM_STATES-1:0] ST_PLAY       = 6'b000100;
    localparam logic [NUM_STATES-1:0] ST_FLASH      = 6'b001000;
    localparam logic [NUM_STATES-1:0] ST_PADDLEFALL = 6'b010000;
    localparam logic [NUM_STATES-1:0] ST_NOPADDLES  = 6'b100000;

    // Only the six named encodings are legal; zero and multi-hot vectors are not.
    function automatic logic legal_state(input logic [NUM_STATES-1:0] s);
        case (s)
            ST_STARTGAME, ST_IDLE, ST_PLAY,
            ST_FLASH, ST_PADDLEFALL, ST_NOPADDLES: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/four_sec_timer.sv
// Saturating 4-second timer with a terminal-count flag and a blink enable tapped from the count.
module four_sec_timer #(
    parameter int TICKS_4SEC = 200_000_000,
    parameter int CNT_W      = 28,
    parameter int BLINK_BIT  = 23
) (
    input  logic clk,
    input  logic reset,
    input  logic resettimer,
    input  logic timecount,
    output logic foursec,
    output logic blink
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_4SEC - 1);

    logic [CNT_W-1:0] cnt;

    // Clear wins over count; the count parks at its last value instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset || resettimer) begin
            cnt <= '0;
        end else if (timecount && cnt != CNT_LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign foursec = (cnt == CNT_LAST);
    assign blink   = timecount & ~cnt[BLINK_BIT];

endmodule

// File: rtl/game_timer_lives.sv
// Present-state register, lives counter and 4-second timer serving the game control FSM.
module game_timer_lives
    import game_timer_lives_pkg::*;
#(
    parameter int TICKS_4SEC = 200_000_000,
    parameter int CNT_W      = 28,
    parameter int NUM_LIVES  = 3,
    parameter int LIVES_W    = 2,
    parameter int BLINK_BIT  = 23
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_STATES-1:0] NS,
    input  logic                  resettimer,
    input  logic                  timecount,
    input  logic                  decrementlives,
    input  logic                  loadlives,
    output logic [NUM_STATES-1:0] PS,
    output logic                  foursec,
    output logic                  nolives,
    output logic [LIVES_W-1:0]    lives,
    output logic                  blink,
    output logic                  state_err
);

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(NUM_LIVES);

    // An illegal next state sends the game back to startgame and leaves a sticky flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            PS        <= ST_STARTGAME;
            state_err <= 1'b0;
        end else if (legal_state(NS)) begin
            PS <= NS;
        end else begin
            PS        <= ST_STARTGAME;
            state_err <= 1'b1;
        end
    end

    // Load wins over decrement; the counter floors at zero.
    always_ff @(posedge clk) begin
        if (reset || loadlives) begin
            lives <= LIVES_INIT;
        end else if (decrementlives && lives != '0) begin
            lives <= lives - 1'b1;
        end
    end

    assign nolives = (lives == '0);

    four_sec_timer #(
        .TICKS_4SEC (TICKS_4SEC),
        .CNT_W      (CNT_W),
        .BLINK_BIT  (BLINK_BIT)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .resettimer (resettimer),
        .timecount  (timecount),
        .foursec    (foursec),
        .blink      (blink)
    );

endmodule
